// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS generator/checker pair: FSM states, counter widths, tap masks.
// Latency: n/a (package only).
// Backpressure: n/a.
package prbs_pkg;

    // Checker FSM: hunting for the sequence, or tracking it.
    typedef enum logic {
        SEARCH = 1'b0,
        LOCK   = 1'b1
    } state_t;

    // Output counter widths.
    localparam int ERR_CNT_W = 16;
    localparam int BIT_CNT_W = 32;

    // Widest register the tap table covers.
    localparam int MAX_N = 32;

    // One-hot mask for a 1-based tap position.
    function automatic logic [MAX_N-1:0] tap_bit(input int t);
        return MAX_N'(1) << (t - 1);
    endfunction

    // Maximal-length feedback taps for an N-bit register.
    // Bit i of the mask selects the bit received i+1 strobes ago, so with the
    // history shifting towards the MSB the next bit is ^(history & mask).
    // Unsupported N returns 0, which makes the prediction constant 0.
    function automatic logic [MAX_N-1:0] tap_mask(input int n);
        logic [MAX_N-1:0] m;
        m = '0;
        case (n)
            2:  m = tap_bit(2)  | tap_bit(1);
            3:  m = tap_bit(3)  | tap_bit(2);
            4:  m = tap_bit(4)  | tap_bit(3);
            5:  m = tap_bit(5)  | tap_bit(3);
            6:  m = tap_bit(6)  | tap_bit(5);
            7:  m = tap_bit(7)  | tap_bit(6);
            8:  m = tap_bit(8)  | tap_bit(6)  | tap_bit(5) | tap_bit(4);
            9:  m = tap_bit(9)  | tap_bit(5);
            10: m = tap_bit(10) | tap_bit(7);
            11: m = tap_bit(11) | tap_bit(9);
            12: m = tap_bit(12) | tap_bit(6)  | tap_bit(4) | tap_bit(1);
            13: m = tap_bit(13) | tap_bit(4)  | tap_bit(3) | tap_bit(1);
            14: m = tap_bit(14) | tap_bit(5)  | tap_bit(3) | tap_bit(1);
            15: m = tap_bit(15) | tap_bit(14);
            16: m = tap_bit(16) | tap_bit(15) | tap_bit(13) | tap_bit(4);
            17: m = tap_bit(17) | tap_bit(14);
            18: m = tap_bit(18) | tap_bit(11);
            19: m = tap_bit(19) | tap_bit(6)  | tap_bit(2) | tap_bit(1);
            20: m = tap_bit(20) | tap_bit(17);
            21: m = tap_bit(21) | tap_bit(19);
            22: m = tap_bit(22) | tap_bit(21);
            23: m = tap_bit(23) | tap_bit(18);
            24: m = tap_bit(24) | tap_bit(23) | tap_bit(22) | tap_bit(17);
            25: m = tap_bit(25) | tap_bit(22);
            26: m = tap_bit(26) | tap_bit(6)  | tap_bit(2) | tap_bit(1);
            27: m = tap_bit(27) | tap_bit(5)  | tap_bit(2) | tap_bit(1);
            28: m = tap_bit(28) | tap_bit(25);
            29: m = tap_bit(29) | tap_bit(27);
            30: m = tap_bit(30) | tap_bit(6)  | tap_bit(4) | tap_bit(1);
            31: m = tap_bit(31) | tap_bit(28);
            32: m = tap_bit(32) | tap_bit(22) | tap_bit(2) | tap_bit(1);
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Synchronises an asynchronous level into the clk domain and flags each rising edge.
// Latency: pos_edge is high for one clk, SYNC_STAGES clk after the input is first sampled high.
// Backpressure: none; exactly one pulse per rising edge of sig.
module edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic pos_edge
);

    // sync_q[SYNC_STAGES-1] is the first metastability-safe copy,
    // sync_q[SYNC_STAGES] is that copy one clk older.
    logic [SYNC_STAGES:0] sync_q;

    // Shift the raw level through the synchroniser plus one history stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-1:0], sig};
        end
    end

    assign pos_edge = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];

endmodule

// File: rtl/prbs_check.sv
// PRBS checker: locks onto an LFSR sequence sampled at recovered-clock edges and counts bit errors.
// Latency: locked_o/err_o/counters update 1 clk after the bit strobe (strobe = data_clk_i edge + 2 clk sync).
// Backpressure: none; every strobe is consumed, strobes must be at least 2 clk apart.
module prbs_check
    import prbs_pkg::*;
#(
    parameter int N        = 8,
    parameter int LOCK_CNT = 16,
    parameter int WIN      = 64,
    parameter int LOSS_THR = 8,
    // Width of err_cnt_o; the count saturates at all-ones of this width.
    parameter int ERR_W    = ERR_CNT_W
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 data_clk_i,
    input  logic                 data_i,
    input  logic                 clr_i,
    output logic                 locked_o,
    output logic                 err_o,
    output logic [ERR_W-1:0]     err_cnt_o,
    output logic [BIT_CNT_W-1:0] bit_cnt_o
);

    localparam int FILL_W = $clog2(N + 1);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int WBIT_W = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int WERR_W = $clog2(LOSS_THR + 1);

    localparam logic [MAX_N-1:0]  TAPS_FULL = tap_mask(N);
    localparam logic [N-1:0]      TAPS      = TAPS_FULL[N-1:0];
    localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(N);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
    localparam logic [WBIT_W-1:0] WBIT_LAST = WBIT_W'(WIN - 1);
    localparam logic [WERR_W-1:0] LOSS_LIM  = WERR_W'(LOSS_THR);

    // ------------------------------------------------------------------
    // Bit strobe from the recovered clock
    // ------------------------------------------------------------------
    logic strobe;

    edge_detect #(
        .SYNC_STAGES (2)
    ) u_data_clk_edge (
        .clk      (clk_i),
        .rst_n    (rst_n_i),
        .sig      (data_clk_i),
        .pos_edge (strobe)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [N-1:0]        hist_q,  hist_d;
    logic [FILL_W-1:0]   fill_q,  fill_d;
    logic [GOOD_W-1:0]   good_q,  good_d;
    logic [WBIT_W-1:0]   wbit_q,  wbit_d;
    logic [WERR_W-1:0]   werr_q,  werr_d;
    logic                err_q;
    logic [ERR_W-1:0]    err_cnt_q;
    logic [BIT_CNT_W-1:0] bit_cnt_q;

    logic                pred;
    logic                mismatch;
    logic [WERR_W-1:0]   werr_inc;
    logic                lock_strobe;
    logic                lock_err;

    // data_i has been stable since the data_clk_i edge that produced the strobe,
    // so it is sampled directly rather than through its own synchroniser.
    assign pred        = ^(hist_q & TAPS);
    assign mismatch    = data_i ^ pred;
    assign werr_inc    = werr_q + WERR_W'(mismatch);
    assign lock_strobe = strobe && (state_q == LOCK);
    assign lock_err    = lock_strobe && mismatch;

    // Next-state for the FSM, history register and the search/window counters.
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        good_d  = good_q;
        wbit_d  = wbit_q;
        werr_d  = werr_q;

        if (strobe) begin
            case (state_q)
                SEARCH: begin
                    // Load the line data; nothing counts until the history is full.
                    hist_d = {hist_q[N-2:0], data_i};
                    if (fill_q != FILL_DONE) begin
                        fill_d = fill_q + 1'b1;
                    end else if (!mismatch) begin
                        if (good_q == GOOD_LAST) begin
                            state_d = LOCK;
                            good_d  = '0;
                            wbit_d  = '0;
                            werr_d  = '0;
                        end else begin
                            good_d = good_q + 1'b1;
                        end
                    end else begin
                        good_d = '0;
                    end
                end

                LOCK: begin
                    // Free-run on our own prediction so one flipped line bit
                    // produces one error instead of one per tap it passes.
                    hist_d = {hist_q[N-2:0], pred};
                    if (werr_inc == LOSS_LIM) begin
                        state_d = SEARCH;
                        fill_d  = '0;
                        good_d  = '0;
                        wbit_d  = '0;
                        werr_d  = '0;
                    end else if (wbit_q == WBIT_LAST) begin
                        // Last bit of the window still counted above; next window starts clean.
                        wbit_d = '0;
                        werr_d = '0;
                    end else begin
                        wbit_d = wbit_q + 1'b1;
                        werr_d = werr_inc;
                    end
                end

                default: begin
                    state_d = SEARCH;
                end
            endcase
        end
    end

    // Register the FSM, history and search/window counters.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= SEARCH;
            hist_q  <= '0;
            fill_q  <= '0;
            good_q  <= '0;
            wbit_q  <= '0;
            werr_q  <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            good_q  <= good_d;
            wbit_q  <= wbit_d;
            werr_q  <= werr_d;
        end
    end

    // One-clk error pulse for each mismatching bit seen while locked.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= lock_err;
        end
    end

    // Saturating error counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_cnt_q <= '0;
        end else if (clr_i) begin
            err_cnt_q <= '0;
        end else if (lock_err && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    // Saturating count of bits checked while locked; clear wins over increment.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bit_cnt_q <= '0;
        end else if (clr_i) begin
            bit_cnt_q <= '0;
        end else if (lock_strobe && (bit_cnt_q != '1)) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
        end
    end

    assign locked_o  = (state_q == LOCK);
    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;
    assign bit_cnt_o = bit_cnt_q;

endmodule

// File: tb/tb_prbs_check.sv
// Self-checking bench for prbs_check: PRBS-8 stream with injected errors against a behavioural model.
// Latency: each bit takes 8 clk (data_clk high 4, low 4); outputs checked at the end of each bit.
// Backpressure: n/a.
module tb_prbs_check;

    localparam int N        = 8;
    localparam int LOCK_CNT = 16;
    localparam int WIN      = 64;
    localparam int LOSS_THR = 8;
    localparam int SAT_W    = 6;
    localparam int SAT_MAX  = (1 << SAT_W) - 1;

    logic        clk;
    logic        rst_n;
    logic        data_clk;
    logic        data;
    logic        data_s;
    logic        clr;
    logic        locked;
    logic        err;
    logic [15:0] err_cnt;
    logic [31:0] bit_cnt;
    logic        locked_s;
    logic        err_s;
    logic [SAT_W-1:0] err_cnt_s;
    logic [31:0] bit_cnt_s;

    prbs_check #(
        .N(N), .LOCK_CNT(LOCK_CNT), .WIN(WIN), .LOSS_THR(LOSS_THR)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .data_clk_i(data_clk), .data_i(data), .clr_i(clr),
        .locked_o(locked), .err_o(err), .err_cnt_o(err_cnt), .bit_cnt_o(bit_cnt)
    );

    // Loss threshold above the window size: loss of lock can never happen.
    prbs_check #(
        .N(N), .LOCK_CNT(LOCK_CNT), .WIN(WIN), .LOSS_THR(WIN + 1), .ERR_W(SAT_W)
    ) dut_sat (
        .clk_i(clk), .rst_n_i(rst_n), .data_clk_i(data_clk), .data_i(data_s), .clr_i(1'b0),
        .locked_o(locked_s), .err_o(err_s), .err_cnt_o(err_cnt_s), .bit_cnt_o(bit_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt   = 0;
    int pulse_s_cnt = 0;
    bit chk_sat  = 1'b0;

    // Count err pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (err === 1'b1)   pulse_cnt++;
        if (err_s === 1'b1) pulse_s_cnt++;
    end

    // PRBS source: b[k] = b[k-8] ^ b[k-6] ^ b[k-5] ^ b[k-4]
    bit gq[$];

    task automatic gen_next(output bit b);
        b = gq[0] ^ gq[2] ^ gq[3] ^ gq[4];
        gq.push_back(b);
        void'(gq.pop_front());
    endtask

    // Behavioural model of the main checker
    bit     m_locked;
    int     m_run;
    int     m_lock_idx;
    int     m_win_errs[int];
    int     m_err;
    longint m_bits;
    int     exp_pulse;
    // Model of the saturation instance (always clean unless inverted)
    bit     s_locked;
    int     s_run;
    int     s_err;
    longint s_bits;

    task automatic model_reset();
        m_locked = 0; m_run = 0; m_lock_idx = 0; m_win_errs.delete();
        m_err = 0; m_bits = 0;
        s_locked = 0; s_run = 0; s_err = 0; s_bits = 0;
    endtask

    task automatic model_step(input bit flip, input bit clr_b);
        int w;
        exp_pulse = 0;
        if (m_locked) begin
            w = m_lock_idx / WIN;
            exp_pulse = int'(flip);
            if (flip && m_err < 65535) m_err++;
            if (m_bits < 64'hFFFF_FFFF) m_bits++;
            if (flip) begin
                if (!m_win_errs.exists(w)) m_win_errs[w] = 0;
                m_win_errs[w]++;
                if (m_win_errs[w] >= LOSS_THR) begin
                    m_locked = 0;
                    m_run = 0;
                end
            end
            m_lock_idx++;
        end else begin
            m_run++;
            if (m_run == N + LOCK_CNT) begin
                m_locked = 1;
                m_lock_idx = 0;
                m_win_errs.delete();
            end
        end
        if (clr_b) begin
            m_err = 0;
            m_bits = 0;
        end
    endtask

    task automatic sat_step(input bit inv);
        if (s_locked) begin
            if (inv && s_err < SAT_MAX) s_err++;
            s_bits++;
        end else begin
            s_run++;
            if (s_run == N + LOCK_CNT) s_locked = 1;
        end
    endtask

    // Send one bit to both checkers, step the models and compare.
    task automatic send_bit(input bit flip, input bit inv, input bit clr_b);
        bit b;
        int p0, p1, ps0, ps1;
        gen_next(b);
        @(negedge clk);
        data = b ^ flip;
        data_s = b ^ inv;
        clr = clr_b;
        data_clk = 1'b1;
        p0 = pulse_cnt;
        ps0 = pulse_s_cnt;
        repeat (4) @(negedge clk);
        data_clk = 1'b0;
        repeat (4) @(negedge clk);
        clr = 1'b0;
        p1 = pulse_cnt;
        ps1 = pulse_s_cnt;
        model_step(flip, clr_b);
        sat_step(inv);
        n_checks++;
        if (locked !== m_locked) begin
            n_fail++; $display("FAIL bit_locked: got %b expected %b", locked, m_locked);
        end
        n_checks++;
        if (err_cnt !== 16'(m_err)) begin
            n_fail++; $display("FAIL bit_err_cnt: got %0d expected %0d", err_cnt, m_err);
        end
        n_checks++;
        if (bit_cnt !== 32'(m_bits)) begin
            n_fail++; $display("FAIL bit_bit_cnt: got %0d expected %0d", bit_cnt, m_bits);
        end
        n_checks++;
        if (p1 - p0 != exp_pulse) begin
            n_fail++; $display("FAIL bit_err_pulses: got %0d expected %0d", p1 - p0, exp_pulse);
        end
        if (chk_sat) begin
            n_checks++;
            if (locked_s !== s_locked) begin
                n_fail++; $display("FAIL sat_locked: got %b expected %b", locked_s, s_locked);
            end
            n_checks++;
            if (err_cnt_s !== SAT_W'(s_err)) begin
                n_fail++; $display("FAIL sat_err_cnt: got %0d expected %0d", err_cnt_s, s_err);
            end
            n_checks++;
            if (ps1 - ps0 != int'(inv)) begin
                n_fail++; $display("FAIL sat_err_pulses: got %0d expected %0d", ps1 - ps0, int'(inv));
            end
        end
    endtask

    task automatic align_window();
        while (m_lock_idx % WIN != 0) send_bit(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b expected 0", locked); end
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        n_checks++;
        if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
        n_checks++;
        if (bit_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_bit_cnt: got %0d expected 0", bit_cnt); end
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_clean_lock();
        int lock_at;
        lock_at = 0;
        for (int i = 1; i <= 1000; i++) begin
            send_bit(1'b0, 1'b0, 1'b0);
            if (locked === 1'b1 && lock_at == 0) lock_at = i;
        end
        n_checks++;
        if (lock_at != 24) begin n_fail++; $display("FAIL clean_lock_strobe: got %0d expected 24", lock_at); end
        n_checks++;
        if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL clean_err_cnt: got %0d expected 0", err_cnt); end
        n_checks++;
        if (bit_cnt !== 32'd976) begin n_fail++; $display("FAIL clean_bit_cnt: got %0d expected 976", bit_cnt); end
    endtask

    task automatic test_single_error();
        int p0;
        p0 = pulse_cnt;
        repeat ($urandom_range(3, 40)) send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        repeat (5) send_bit(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (pulse_cnt - p0 != 1) begin n_fail++; $display("FAIL single_pulses: got %0d expected 1", pulse_cnt - p0); end
        n_checks++;
        if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL single_err_cnt: got %0d expected 1", err_cnt); end
        n_checks++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL single_locked: got %b expected 1", locked); end
    endtask

    task automatic test_clear_on_error();
        send_bit(1'b1, 1'b0, 1'b1);
        n_checks++;
        if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_err_cnt: got %0d expected 0", err_cnt); end
        n_checks++;
        if (bit_cnt !== 32'd0) begin n_fail++; $display("FAIL clr_bit_cnt: got %0d expected 0", bit_cnt); end
        send_bit(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL clr_after_err_cnt: got %0d expected 1", err_cnt); end
    endtask

    task automatic test_loss();
        bit flags [64];
        int cnt, o, last_err, fell_at, relock_at;
        send_bit(1'b0, 1'b0, 1'b1);
        align_window();
        foreach (flags[i]) flags[i] = 1'b0;
        cnt = 0;
        while (cnt < LOSS_THR) begin
            o = $urandom_range(0, WIN - 1);
            if (!flags[o]) begin flags[o] = 1'b1; cnt++; end
        end
        last_err = 0;
        foreach (flags[i]) if (flags[i]) last_err = i;
        fell_at = -1;
        for (int i = 0; i < WIN; i++) begin
            send_bit(flags[i], 1'b0, 1'b0);
            if (locked === 1'b0) begin fell_at = i; break; end
        end
        n_checks++;
        if (fell_at != last_err) begin n_fail++; $display("FAIL loss_offset: got %0d expected %0d", fell_at, last_err); end
        n_checks++;
        if (err_cnt !== 16'd8) begin n_fail++; $display("FAIL loss_err_cnt: got %0d expected 8", err_cnt); end
        relock_at = 0;
        for (int i = 1; i <= 30; i++) begin
            send_bit(1'b0, 1'b0, 1'b0);
            if (locked === 1'b1 && relock_at == 0) relock_at = i;
        end
        n_checks++;
        if (relock_at != 24) begin n_fail++; $display("FAIL loss_relock_strobe: got %0d expected 24", relock_at); end
        n_checks++;
        if (err_cnt !== 16'd8) begin n_fail++; $display("FAIL loss_retained_err_cnt: got %0d expected 8", err_cnt); end
    endtask

    task automatic test_window_boundary();
        bit flags [2*WIN];
        int cnt, o, p0;
        send_bit(1'b0, 1'b0, 1'b1);
        align_window();
        foreach (flags[i]) flags[i] = 1'b0;
        // Errors straddle the boundary: last bit of window k, first of window k+1.
        flags[WIN-1] = 1'b1;
        flags[WIN]   = 1'b1;
        for (int w = 0; w < 2; w++) begin
            cnt = 1;
            while (cnt < LOSS_THR - 1) begin
                o = w * WIN + $urandom_range(0, WIN - 1);
                if (!flags[o]) begin flags[o] = 1'b1; cnt++; end
            end
        end
        p0 = pulse_cnt;
        foreach (flags[i]) send_bit(flags[i], 1'b0, 1'b0);
        n_checks++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL window_locked: got %b expected 1", locked); end
        n_checks++;
        if (err_cnt !== 16'd14) begin n_fail++; $display("FAIL window_err_cnt: got %0d expected 14", err_cnt); end
        n_checks++;
        if (pulse_cnt - p0 != 14) begin n_fail++; $display("FAIL window_pulses: got %0d expected 14", pulse_cnt - p0); end
    endtask

    task automatic test_reset_mid_lock();
        int relock_at;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL midrst_locked: got %b expected 0", locked); end
        n_checks++;
        if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_err_cnt: got %0d expected 0", err_cnt); end
        n_checks++;
        if (bit_cnt !== 32'd0) begin n_fail++; $display("FAIL midrst_bit_cnt: got %0d expected 0", bit_cnt); end
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %b expected 0", err); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        relock_at = 0;
        for (int i = 1; i <= 30; i++) begin
            send_bit(1'b0, 1'b0, 1'b0);
            if (locked === 1'b1 && relock_at == 0) relock_at = i;
        end
        n_checks++;
        if (relock_at != 24) begin n_fail++; $display("FAIL midrst_relock_strobe: got %0d expected 24", relock_at); end
    endtask

    task automatic test_saturation();
        chk_sat = 1'b1;
        send_bit(1'b0, 1'b0, 1'b0);
        repeat (SAT_MAX + 7) send_bit(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (err_cnt_s !== SAT_W'(SAT_MAX)) begin
            n_fail++; $display("FAIL sat_hold: got %0d expected %0d", err_cnt_s, SAT_MAX);
        end
        n_checks++;
        if (locked_s !== 1'b1) begin n_fail++; $display("FAIL sat_lock_held: got %b expected 1", locked_s); end
        n_checks++;
        if (bit_cnt_s !== 32'(s_bits)) begin
            n_fail++; $display("FAIL sat_bit_cnt: got %0d expected %0d", bit_cnt_s, s_bits);
        end
        chk_sat = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; data_clk = 1'b0; data = 1'b0; data_s = 1'b0; clr = 1'b0;
        for (int i = 0; i < N; i++) gq.push_back(bit'($urandom_range(0, 1)));
        gq[N-1] = 1'b1;
        model_reset();
        test_reset();
        test_clean_lock();
        test_single_error();
        test_clear_on_error();
        test_loss();
        test_window_boundary();
        test_reset_mid_lock();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
